// File: rtl/acc_multi_pkg.sv
// acc_multi_pkg: mode encodings, job states and the output lane reduction.
// Build option ACC_SATURATE_EN makes reduce_lane clamp instead of pass-through (caller truncates).
package acc_multi_pkg;
   localparam logic [1:0] ACC_MODE_SUM = 2'd0;
   localparam logic [1:0] ACC_MODE_MAX = 2'd1;
   localparam logic [1:0] ACC_MODE_MIN = 2'd2;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } acc_state_e;

   // Brings a sign-extended buffer lane into dw-bit range; the caller keeps the low dw bits.
   function automatic logic signed [63:0] reduce_lane(input logic signed [63:0] acc, input int dw);
`ifdef ACC_SATURATE_EN
      logic signed [63:0] hi_v;
      logic signed [63:0] lo_v;
      hi_v = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo_v = -(64'sd1 <<< (dw - 1));
      if (acc > hi_v) begin
         return hi_v;
      end else if (acc < lo_v) begin
         return lo_v;
      end else begin
         return acc;
      end
`else
      return acc;
`endif
   endfunction
endpackage

// File: rtl/acc_multi_if.sv
// acc_multi_if: valid/avail stream in and out of the grouped accumulator.
interface acc_multi_if #(
   parameter int DATA_WIDTH = 8,
   parameter int GROUP_SIZE = 4
);
   logic [GROUP_SIZE*DATA_WIDTH-1:0] data_in;
   logic                             valid_in;
   logic                             avail_out;
   logic [GROUP_SIZE*DATA_WIDTH-1:0] data_out;
   logic                             valid_out;
   logic                             avail_in;

   modport master (
      output data_in, valid_in, avail_in,
      input  avail_out, data_out, valid_out
   );

   modport slave (
      input  data_in, valid_in, avail_in,
      output avail_out, data_out, valid_out
   );
endinterface

// File: rtl/acc_multi_chk.sv
// acc_multi_chk: flags upstream writes that arrive while the input FIFO is full.
module acc_multi_chk (
   input logic clk,
   input logic rst,
   input logic valid_in,
   input logic full
);
   a_no_write_when_full: assert property (@(posedge clk) disable iff (!rst) !(valid_in && full));
endmodule

// File: rtl/acc_multi_lane.sv
// acc_multi_lane: one lane of combine (store / sum / max / min) plus output reduction.
module acc_multi_lane #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 16
) (
   input  logic                         first_s,
   input  logic [1:0]                   mode_s,
   input  logic signed [DATA_WIDTH-1:0] in_s,
   input  logic signed [ACC_WIDTH-1:0]  buf_s,
   output logic signed [ACC_WIDTH-1:0]  acc_s,
   output logic signed [DATA_WIDTH-1:0] red_s
);
   import acc_multi_pkg::*;

   logic signed [ACC_WIDTH-1:0] in_ext_s;

   assign in_ext_s = ACC_WIDTH'(in_s);

   // Per-lane combine; reserved mode falls back to sum
   always_comb begin
      acc_s = in_ext_s;
      if (first_s) begin
         acc_s = in_ext_s;
      end else begin
         case (mode_s)
            ACC_MODE_MAX: acc_s = (buf_s > in_ext_s) ? buf_s : in_ext_s;
            ACC_MODE_MIN: acc_s = (buf_s < in_ext_s) ? buf_s : in_ext_s;
            default:      acc_s = buf_s + in_ext_s;
         endcase
      end
   end

   assign red_s = DATA_WIDTH'(reduce_lane(64'(acc_s), DATA_WIDTH));
endmodule

// File: rtl/acc_multi.sv
// acc_multi: grouped multi-pass accumulator (sum/max/min) with input FIFO and pass buffer.
// Build option ACC_SATURATE_EN clamps output lanes; otherwise they are truncated.
module acc_multi #(
   parameter int DATA_WIDTH             = 8,
   parameter int ACC_WIDTH              = 16,
   parameter int GROUP_SIZE             = 4,
   parameter int LOG_MAX_ITERS          = 16,
   parameter int LOG_MAX_READS_PER_ITER = 16,
   parameter int NUM_ADDRESSES          = 65536,
   parameter int FIFO_SLOTS             = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              configure,
   input  logic [LOG_MAX_ITERS-1:0]          num_iters,
   input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
   input  logic [1:0]                        mode,
   acc_multi_if.slave                        bus,
   output logic                              busy,
   output logic                              done
);
   import acc_multi_pkg::*;

   localparam int PTR_W  = $clog2(FIFO_SLOTS);
   localparam int LANE_W = GROUP_SIZE * DATA_WIDTH;
   localparam int BUF_W  = GROUP_SIZE * ACC_WIDTH;
   localparam int AVAIL_MAX = FIFO_SLOTS - 2;
   localparam logic [PTR_W:0] CNT_FULL  = FIFO_SLOTS[PTR_W:0];
   localparam logic [PTR_W:0] CNT_AVAIL = AVAIL_MAX[PTR_W:0];

   acc_state_e                        state_r;
   logic [LANE_W-1:0]                 fifo_mem_r [FIFO_SLOTS];
   logic [BUF_W-1:0]                  buf_mem_r  [NUM_ADDRESSES];
   logic [PTR_W-1:0]                  wr_ptr_r, rd_ptr_r;
   logic [PTR_W:0]                    count_r;
   logic [LOG_MAX_ITERS-1:0]          iters_r, pass_r;
   logic [LOG_MAX_READS_PER_ITER-1:0] reads_r, addr_r;
   logic [1:0]                        mode_r;
   logic                              busy_r, done_r;
   logic                              push_s, op_s, full_s, first_s, last_s, addr_end_s, valid_s;
   logic [LANE_W-1:0]                 head_s, red_bus_s;
   logic [BUF_W-1:0]                  rd_buf_s, acc_bus_s;

   assign full_s     = (count_r == CNT_FULL);
   assign push_s     = bus.valid_in & ~full_s;
   assign first_s    = ~|pass_r;
   assign last_s     = (pass_r == iters_r - LOG_MAX_ITERS'(1'b1));
   assign addr_end_s = (addr_r == reads_r - LOG_MAX_READS_PER_ITER'(1'b1));
   // Downstream back-pressure only stalls the pass that produces output
   assign op_s       = busy_r & (|count_r) & (bus.avail_in | ~last_s);
   assign valid_s    = op_s & last_s;
   assign head_s     = fifo_mem_r[rd_ptr_r];
   assign rd_buf_s   = buf_mem_r[addr_r];

   assign bus.avail_out = (count_r <= CNT_AVAIL);
   assign bus.valid_out = valid_s;
   assign bus.data_out  = valid_s ? red_bus_s : {LANE_W{1'b0}};
   assign busy          = busy_r;
   assign done          = done_r;

   for (genvar g = 0; g < GROUP_SIZE; g++) begin : g_lane
      acc_multi_lane #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_lane (
         .first_s (first_s),
         .mode_s  (mode_r),
         .in_s    (head_s[g*DATA_WIDTH +: DATA_WIDTH]),
         .buf_s   (rd_buf_s[g*ACC_WIDTH +: ACC_WIDTH]),
         .acc_s   (acc_bus_s[g*ACC_WIDTH +: ACC_WIDTH]),
         .red_s   (red_bus_s[g*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   // FIFO slots and pass buffer hold data only, so they carry no reset
   always_ff @(posedge clk) begin
      if (push_s) fifo_mem_r[wr_ptr_r] <= bus.data_in;
      if (op_s)   buf_mem_r[addr_r]    <= acc_bus_s;
   end

   // Input FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {(PTR_W+1){1'b0}};
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
         if (op_s)   rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
         case ({push_s, op_s})
            2'b10:   count_r <= count_r + (PTR_W+1)'(1'b1);
            2'b01:   count_r <= count_r - (PTR_W+1)'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Job control: configuration capture, address/pass sequencing, busy and done
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         iters_r <= {LOG_MAX_ITERS{1'b0}};
         pass_r  <= {LOG_MAX_ITERS{1'b0}};
         reads_r <= {LOG_MAX_READS_PER_ITER{1'b0}};
         addr_r  <= {LOG_MAX_READS_PER_ITER{1'b0}};
         mode_r  <= ACC_MODE_SUM;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (configure) begin
                  iters_r <= num_iters;
                  reads_r <= num_reads_per_iter;
                  mode_r  <= mode;
                  pass_r  <= {LOG_MAX_ITERS{1'b0}};
                  addr_r  <= {LOG_MAX_READS_PER_ITER{1'b0}};
                  if ((~|num_iters) || (~|num_reads_per_iter)) begin
                     done_r <= 1'b1;
                  end else begin
                     state_r <= ST_RUN;
                     busy_r  <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (op_s) begin
                  if (addr_end_s) begin
                     addr_r <= {LOG_MAX_READS_PER_ITER{1'b0}};
                     if (last_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                     end else begin
                        pass_r <= pass_r + LOG_MAX_ITERS'(1'b1);
                     end
                  end else begin
                     addr_r <= addr_r + LOG_MAX_READS_PER_ITER'(1'b1);
                  end
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   acc_multi_chk u_chk (
      .clk      (clk),
      .rst      (rst),
      .valid_in (bus.valid_in),
      .full     (full_s)
   );
endmodule

// File: tb/tb_acc_multi.sv
// tb_acc_multi: directed and randomized jobs checked against an arithmetic model of the accumulator.
module tb_acc_multi;
   logic        clk = 1'b0;
   logic        rst;
   logic        configure;
   logic [15:0] cfg_iters;
   logic [15:0] cfg_reads;
   logic [1:0]  cfg_mode;
   logic        busy;
   logic        done;

   acc_multi_if #(.DATA_WIDTH(8), .GROUP_SIZE(4)) bus ();

   acc_multi dut (
      .clk                (clk),
      .rst                (rst),
      .configure          (configure),
      .num_iters          (cfg_iters),
      .num_reads_per_iter (cfg_reads),
      .mode               (cfg_mode),
      .bus                (bus),
      .busy               (busy),
      .done               (done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   logic [31:0] beats_q[$];
   logic [31:0] exp_q[$];
   int          nout, done_n, done_c, first_v, last_v;
   logic        avail_hold;
   logic [31:0] last_out;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int wrap16(input int v);
      int m;
      m = v & 32'h0000FFFF;
      if (m >= 32768) m = m - 65536;
      return m;
   endfunction

   function automatic logic [7:0] to_out(input int v);
      int t;
      t = v;
`ifdef ACC_SATURATE_EN
      if (t > 127) t = 127;
      else if (t < -128) t = -128;
`endif
      return t[7:0];
   endfunction

   // Expected last-pass outputs: element-wise combine over passes, per address and lane
   task automatic build_expect(input int it, input int rd, input int md);
      int          acc [64][4];
      int          x;
      logic [31:0] w;
      exp_q.delete();
      for (int p = 0; p < it; p++) begin
         for (int r = 0; r < rd; r++) begin
            w = 32'h0;
            for (int l = 0; l < 4; l++) begin
               x = $signed(beats_q[p*rd + r][l*8 +: 8]);
               if (p == 0) acc[r][l] = x;
               else if (md == 1) acc[r][l] = (x > acc[r][l]) ? x : acc[r][l];
               else if (md == 2) acc[r][l] = (x < acc[r][l]) ? x : acc[r][l];
               else acc[r][l] = wrap16(acc[r][l] + x);
               w[l*8 +: 8] = to_out(acc[r][l]);
            end
            if (p == it - 1) exp_q.push_back(w);
         end
      end
   endtask

   task automatic fill_const(input int n, input logic [7:0] v);
      for (int i = 0; i < n; i++) beats_q.push_back({4{v}});
   endtask

   task automatic fill_rand(input int n);
      for (int i = 0; i < n; i++) beats_q.push_back($urandom());
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, ".avail_out"}, 32'(bus.avail_out), 32'd1);
      chk({tag, ".valid_out"}, 32'(bus.valid_out), 32'd0);
      chk({tag, ".data_out"},  bus.data_out,        32'd0);
      chk({tag, ".busy"},      32'(busy),           32'd0);
      chk({tag, ".done"},      32'(done),           32'd0);
   endtask

   // Runs one job from posedge+1 and ends at posedge+1; abort_at >= 0 resets the DUT mid-job
   task automatic run_job(input int it, input int rd, input int md, input int hold,
                          input int abort_at, input string tag);
      int sent, total, cyc, budget;
      total = it * rd;
      build_expect(it, rd, md);
      nout = 0; done_n = 0; done_c = -10; first_v = -1; last_v = -1;
      avail_hold = 1'b1; sent = 0; budget = total * 2 + hold + 40;
      configure = 1'b1; cfg_iters = 16'(it); cfg_reads = 16'(rd); cfg_mode = 2'(md);
      @(posedge clk); #1;
      configure = 1'b0;
      chk({tag, ".busy_rise"}, 32'(busy), 32'd1);
      cyc = 0;
      while (cyc < budget) begin
         configure = (cyc == 1);
         if (cyc == 1) begin
            cfg_iters = 16'd0;
            cfg_mode  = 2'd2;
         end
         bus.avail_in = (cyc >= hold);
         bus.valid_in = (sent < total) && bus.avail_out;
         bus.data_in  = (sent < total) ? beats_q[sent] : 32'h0;
         if (cyc == abort_at) begin
            #2 rst = 1'b0;
            #1 chk_reset_values({tag, ".async_rst"});
            bus.valid_in = 1'b0;
            configure = 1'b0;
            @(posedge clk); #1;
            rst = 1'b1;
            return;
         end
         @(negedge clk);
         if (bus.valid_out) begin
            if (nout < exp_q.size()) chk({tag, ".data_out"}, bus.data_out, exp_q[nout]);
            last_out = bus.data_out;
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
            nout++;
         end
         if (done) begin
            done_n++;
            done_c = cyc;
         end
         if (cyc == hold - 1) avail_hold = bus.avail_out;
         if (bus.valid_in) sent++;
         @(posedge clk); #1;
         cyc++;
         if (done_n > 0 && cyc > done_c + 2) break;
      end
      configure = 1'b0;
      bus.valid_in = 1'b0;
      bus.avail_in = 1'b1;
      chk({tag, ".out_count"},   32'(nout),   32'(exp_q.size()));
      chk({tag, ".done_count"},  32'(done_n), 32'd1);
      chk({tag, ".done_timing"}, 32'(done_c), 32'(last_v + 1));
      chk({tag, ".busy_end"},    32'(busy),   32'd0);
   endtask

   initial begin
      rst = 1'b0; configure = 1'b0; cfg_iters = 16'd0; cfg_reads = 16'd0; cfg_mode = 2'd0;
      bus.valid_in = 1'b0; bus.avail_in = 1'b1; bus.data_in = 32'h0;
      #12;
      chk_reset_values("reset");
      @(posedge clk); #1;
      rst = 1'b1;

      // sum of three passes of 100
      beats_q.delete(); fill_const(6, 8'd100);
      run_job(3, 2, 0, 0, -1, "sum3x2");
`ifdef ACC_SATURATE_EN
      chk("sum3x2.final", last_out, 32'h7F7F7F7F);
`else
      chk("sum3x2.final", last_out, 32'h2C2C2C2C);
`endif

      // max / min over -5 then -3, single address
      beats_q.delete(); fill_const(1, 8'hFB); fill_const(1, 8'hFD);
      run_job(2, 1, 1, 0, -1, "max");
      chk("max.final", last_out, 32'hFDFDFDFD);
      run_job(2, 1, 2, 0, -1, "min");
      chk("min.final", last_out, 32'hFBFBFBFB);

      // single pass: output equals input
      beats_q.delete(); fill_rand(4);
      run_job(1, 4, 0, 0, -1, "pass1");

      // downstream held off through the last pass
      beats_q.delete(); fill_rand(8);
      run_job(2, 4, 0, 20, -1, "hold");
      chk("hold.avail_low", 32'(avail_hold),      32'd0);
      chk("hold.first_out", 32'(first_v),         32'd20);
      chk("hold.burst",     32'(last_v - first_v), 32'd3);

      // zero counts: no busy, done next cycle, re-configure on the done cycle
      configure = 1'b1; cfg_iters = 16'd0; cfg_reads = 16'd5; cfg_mode = 2'd0;
      @(posedge clk); #1;
      cfg_iters = 16'd3; cfg_reads = 16'd0;
      @(negedge clk);
      chk("zero.done",  32'(done), 32'd1);
      chk("zero.busy",  32'(busy), 32'd0);
      @(posedge clk); #1;
      configure = 1'b0;
      @(negedge clk);
      chk("zero.done_again", 32'(done), 32'd1);
      chk("zero.busy_again", 32'(busy), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("zero.done_low", 32'(done), 32'd0);
      @(posedge clk); #1;

      // reset during the second pass, then a fresh job
      beats_q.delete(); fill_rand(12);
      run_job(3, 4, 0, 0, 6, "abort");
      beats_q.delete(); fill_rand(12);
      run_job(3, 4, 0, 0, -1, "after_rst");

      // randomized jobs across all modes
      for (int j = 0; j < 8; j++) begin
         int it, rd, md;
         it = $urandom_range(1, 4);
         rd = $urandom_range(1, 6);
         md = $urandom_range(0, 3);
         beats_q.delete(); fill_rand(it * rd);
         run_job(it, rd, md, 0, -1, $sformatf("rand%0d", j));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/acc_multi.md
# acc_multi

Multi-mode grouped accumulator, the parametrised successor of the single-mode accumulator in the convolution output path. It receives GROUP_SIZE lanes per beat and combines them element-wise across num_iters passes of num_reads_per_iter beats each, using an on-chip buffer. Lanes are combined by signed sum, max or min into a widened ACC_WIDTH buffer, and results are emitted at DATA_WIDTH on the final pass. It sits between the conv/pool datapath and the output writer, using the codebase's valid/avail handshake.

## Interface
- DATA_WIDTH, 8, signed lane width in and out
- ACC_WIDTH, 16, signed buffer lane width (≥ DATA_WIDTH)
- GROUP_SIZE, 4, lanes per beat
- LOG_MAX_ITERS, 16, num_iters width
- LOG_MAX_READS_PER_ITER, 16, num_reads_per_iter width and buffer address width
- NUM_ADDRESSES, 65536, buffer depth
- FIFO_SLOTS, 4, input FIFO depth (power of two, ≥ 2)

Ports:
- clk  in  1  clock; everything is rising-edge
- rst  in  1  asynchronous, active-low reset
- configure  in  1  load configuration (one-cycle pulse)
- num_iters  in  LOG_MAX_ITERS  passes
- num_reads_per_iter  in  LOG_MAX_READS_PER_ITER  beats per pass
- mode  in  2  0 = sum, 1 = max, 2 = min, 3 = reserved (treated as sum)
- data_in  in  GROUP_SIZE*DATA_WIDTH  lane i at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
- valid_in  in  1  data_in valid
- avail_out  out  1  upstream may send next cycle
- data_out  out  GROUP_SIZE*DATA_WIDTH  result
- valid_out  out  1  data_out valid
- avail_in  in  1  downstream can accept
- busy  out  1  job in progress
- done  out  1  one-cycle end-of-job pulse

## Operation
- Idle state: a configure pulse latches num_iters, num_reads_per_iter and mode, then sets busy.
  - configure while busy is ignored.
  - If either count is 0, the block does not set busy; it pulses done the next cycle.
- Op fires when all of these hold: busy & FIFO non-empty & (avail_in | not last pass).
- On each op:
  - pop one beat;
  - read the buffer at addr;
  - compute per lane;
  - write the result back to addr.
- Address sequence:
  - addr counts 0 up to num_reads_per_iter-1;
  - it wraps to 0 and increments the pass counter at the end of each pass.
- Per-lane computation (input sign-extended to ACC_WIDTH):
  - First pass stores the input.
  - Later passes compute buf+in (sum, wraps modulo 2^ACC_WIDTH), max(buf,in) or min(buf,in), all signed.
- Last pass:
  - valid_out = op;
  - data_out = computed lanes reduced to DATA_WIDTH (see Configuration);
  - the buffer write still occurs.
- A single-pass job (num_iters = 1) is both first and last: the output is the input passed through the reduction.
- End of job: after the op with addr = reads-1 on the last pass, busy clears and done pulses the next cycle.
- avail_out = FIFO free slots ≥ 2.
  - A write into a full FIFO is dropped.
  - A simulation assertion flags it.
- Reset mid-job: FIFO is emptied, counters are zeroed, busy clears; buffer contents are don't-care.

## Timing
- Reset values: avail_out 1, valid_out 0, data_out 0, busy 0, done 0.
- The buffer has a combinational read and a synchronous write.
- Compute is combinational from the FIFO head, so valid_out/data_out are asserted in the same cycle as the op (FIFO-to-output latency 0).
- A beat written at cycle t is poppable at t+1.
- Throughput is one op per cycle.
- Back-to-back passes have no bubble at the pass boundary.
- Read-after-write: reads == 1 reuses the same address every cycle, so the write at t must be visible to the read at t+1.
- busy rises the cycle after configure.
- A new configure is accepted the cycle after done.

## Configuration
- ACC_SATURATE_EN defined: output lanes clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Not defined: output lanes are the low DATA_WIDTH bits of the buffer lane (truncation).
- In both cases the buffer always holds the full ACC_WIDTH value.

## Structure
- Package acc_multi_pkg:
  - mode encoding constants (ACC_MODE_SUM/MAX/MIN);
  - the reduce/saturate function.
- Sub-module acc_multi_lane, instanced GROUP_SIZE times:
  - inputs: first flag, mode, in, buf;
  - outputs: acc value and reduced value.
- Reuse the existing FIFO and MEMU (unregistered-output) modules.

## Test plan
- Sum, num_iters = 3, reads = 2, lanes of 100 each beat, avail_in = 1, saturation on:
  - buffer holds 300 per lane;
  - data_out = 127 on the 2 last-pass beats;
  - with the macro off, data_out = 44 (300 mod 256).
- Max mode, 2 passes, reads = 1, inputs -5 then -3 → data_out = -3.
- Min mode, same inputs → data_out = -5.
- num_iters = 1, reads = 4:
  - valid_out follows each pop with data_out = data_in;
  - done pulses exactly once, one cycle after the 4th op.
- avail_in held 0 during the last pass:
  - no ops;
  - the FIFO fills and avail_out drops at 3 entries;
  - release → 4 outputs in consecutive cycles.
- configure with num_iters = 0 → no busy, done pulse next cycle.
- Async reset mid-pass 2 → outputs reach reset values immediately; a fresh job then runs correctly.
